reg_file: RTL and testbench

Architectural register file for the single-cycle CPU. It sits directly upstream of the ALU: its two read ports drive the ALU's `alu_ra` and `alu_rb` operands, and its write port takes the writeback value (ALU result or load data, selected outside this block). It has 32 general registers of 32 bits, with register 0 hardwired to zero, plus a debug read port for benches and board display.

---
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file: two combinational operand read ports, one debug read port,
// one synchronous write port; register 0 is hardwired to zero.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rf_rs_addr,
  input  logic [ADDR_W-1:0] rf_rt_addr,
  output logic [DATA_W-1:0] rf_ra,
  output logic [DATA_W-1:0] rf_rb,
  input  logic              cu_reg_we,
  input  logic [ADDR_W-1:0] rf_wr_addr,
  input  logic [DATA_W-1:0] rf_wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [NumRegs-1:0][DATA_W-1:0] mem_q, mem_d;

  // Entry 0 is cleared by reset and never written, so it stays zero as well.
  always_comb begin
    mem_d = mem_q;
    if (cu_reg_we && (rf_wr_addr != '0)) begin
      mem_d[rf_wr_addr] = rf_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads come straight from storage with no write bypass; the writeback value depends
  // combinationally on these ports, so a bypass would close a loop.
  always_comb begin
    rf_ra    = (rf_rs_addr == '0) ? '0 : mem_q[rf_rs_addr];
    rf_rb    = (rf_rt_addr == '0) ? '0 : mem_q[rf_rt_addr];
    dbg_data = (dbg_addr == '0)   ? '0 : mem_q[dbg_addr];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an
// array model of the architectural registers.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rf_rs_addr;
  logic [AW-1:0] rf_rt_addr;
  logic [DW-1:0] rf_ra;
  logic [DW-1:0] rf_rb;
  logic          cu_reg_we;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model [NR];

  reg_file #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rf_rs_addr(rf_rs_addr),
    .rf_rt_addr(rf_rt_addr),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .cu_reg_we (cu_reg_we),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_read(input int idx);
    return (idx == 0) ? '0 : model[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // One write through a single rising edge; the model follows the architectural rule.
  task automatic do_write(input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    cu_reg_we  = 1'b1;
    rf_wr_addr = AW'(addr);
    rf_wr_data = data;
    @(posedge clk);
    #1;
    cu_reg_we = 1'b0;
    if (addr != 0) model[addr] = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    #100;
    n_checks++;
    if (rf_ra !== '0 || rf_rb !== '0) begin
      n_fail++;
      $display("FAIL reset_ports: ra=%h rb=%h required 0", rf_ra, rf_rb);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      n_checks++;
      if (dbg_data !== 32'h0000_0000) begin
        n_fail++;
        $display("FAIL reset_dbg[%0d]: got %h required 00000000", i, dbg_data);
      end
    end
  endtask

  task automatic test_write_hold();
    do_write(5, 32'hDEAD_BEEF);
    rf_rs_addr = 5'd5;
    rf_rt_addr = 5'd5;
    #1;
    n_checks++;
    if (rf_ra !== 32'hDEAD_BEEF || rf_rb !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write5: ra=%h rb=%h required deadbeef", rf_ra, rf_rb);
    end
    @(negedge clk);
    cu_reg_we  = 1'b0;
    rf_wr_addr = 5'd5;
    rf_wr_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    n_checks++;
    if (rf_ra !== 32'hDEAD_BEEF || rf_rb !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL we0_hold: ra=%h rb=%h required deadbeef", rf_ra, rf_rb);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    rf_rs_addr = '0;
    cu_reg_we  = 1'b1;
    rf_wr_addr = '0;
    rf_wr_data = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (rf_ra !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_before: ra=%h required 00000000", rf_ra);
    end
    @(posedge clk);
    #1;
    cu_reg_we = 1'b0;
    n_checks++;
    if (rf_ra !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_after: ra=%h required 00000000", rf_ra);
    end
  endtask

  task automatic test_no_bypass();
    do_write(1, 32'h0000_0001);
    @(negedge clk);
    rf_rs_addr = 5'd1;
    cu_reg_we  = 1'b1;
    rf_wr_addr = 5'd1;
    rf_wr_data = 32'h0000_0002;
    #1;
    n_checks++;
    if (rf_ra !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL bypass_before: ra=%h required 00000001", rf_ra);
    end
    @(posedge clk);
    #1;
    cu_reg_we = 1'b0;
    model[1]  = 32'h0000_0002;
    n_checks++;
    if (rf_ra !== 32'h0000_0002) begin
      n_fail++;
      $display("FAIL bypass_after: ra=%h required 00000002", rf_ra);
    end
  endtask

  task automatic test_fill_pairs();
    logic [DW-1:0] exp_a, exp_b;
    for (int i = 1; i < NR; i++) do_write(i, 32'h100 + DW'(i));
    for (int i = 0; i < NR; i++) begin
      rf_rs_addr = AW'(i);
      rf_rt_addr = AW'(31 - i);
      exp_a = (i == 0) ? 32'h0 : 32'h100 + DW'(i);
      exp_b = (i == 31) ? 32'h0 : 32'h100 + DW'(31 - i);
      #1;
      n_checks++;
      if (rf_ra !== exp_a || rf_rb !== exp_b) begin
        n_fail++;
        $display("FAIL pair[%0d]: ra=%h rb=%h required %h %h", i, rf_ra, rf_rb, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_async_reset();
    do_write(7, 32'hA5A5_A5A5);
    rf_rs_addr = 5'd7;
    #1;
    n_checks++;
    if (rf_ra !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL pre_reset: ra=%h required a5a5a5a5", rf_ra);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (rf_ra !== 32'h0) begin
      n_fail++;
      $display("FAIL async_clear: ra=%h required 00000000", rf_ra);
    end
    // Write presented across an edge while reset is held must be dropped.
    cu_reg_we  = 1'b1;
    rf_wr_addr = 5'd3;
    rf_wr_data = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    @(negedge clk);
    cu_reg_we = 1'b0;
    rst       = 1'b0;
    dbg_addr  = 5'd3;
    #1;
    n_checks++;
    if (dbg_data !== 32'h0) begin
      n_fail++;
      $display("FAIL write_in_reset: dbg=%h required 00000000", dbg_data);
    end
  endtask

  task automatic test_random();
    int wa;
    logic [DW-1:0] wd;
    logic we;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we         = 1'($urandom_range(0, 1));
      wa         = (n % 16 == 0) ? 0 : int'($urandom_range(0, NR - 1));
      wd         = $urandom;
      cu_reg_we  = we;
      rf_wr_addr = AW'(wa);
      rf_wr_data = wd;
      rf_rs_addr = (n % 4 == 1) ? AW'(wa) : AW'($urandom_range(0, NR - 1));
      rf_rt_addr = AW'($urandom_range(0, NR - 1));
      dbg_addr   = AW'($urandom_range(0, NR - 1));
      #1;
      n_checks++;
      if (rf_ra !== model_read(int'(rf_rs_addr)) || rf_rb !== model_read(int'(rf_rt_addr)) ||
          dbg_data !== model_read(int'(dbg_addr))) begin
        n_fail++;
        $display("FAIL rand_pre[%0d]: ra=%h rb=%h dbg=%h required %h %h %h", n, rf_ra, rf_rb,
                 dbg_data, model_read(int'(rf_rs_addr)), model_read(int'(rf_rt_addr)),
                 model_read(int'(dbg_addr)));
      end
      @(posedge clk);
      #1;
      if (we && wa != 0) model[wa] = wd;
      n_checks++;
      if (rf_ra !== model_read(int'(rf_rs_addr)) || rf_rb !== model_read(int'(rf_rt_addr))) begin
        n_fail++;
        $display("FAIL rand_post[%0d]: ra=%h rb=%h required %h %h", n, rf_ra, rf_rb,
                 model_read(int'(rf_rs_addr)), model_read(int'(rf_rt_addr)));
      end
    end
    cu_reg_we = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rf_rs_addr = '0;
    rf_rt_addr = '0;
    cu_reg_we  = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    dbg_addr   = '0;
    test_reset();
    test_write_hold();
    test_zero_reg();
    test_no_bypass();
    test_fill_pairs();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
